// File: rtl/channel_arq_controller.sv
// Stop-and-wait ARQ over a fixed-latency noisy channel; delivery CH_LATENCY+2 edges after accept, +CH_LATENCY+2 per retry.
// One sample in flight: s_ready only in IDLE, result held in OUT until m_ready.
module channel_arq_controller #(
  parameter int DATA_W      = 24,
  parameter int CH_LATENCY  = 2,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] ch_data_in,
  input  logic [DATA_W-1:0] ch_data_out,
  input  logic              ch_error,
  output logic              noise_off,
  input  logic              cfg_noise_off,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_bad,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);
  localparam int WW = $clog2(CH_LATENCY + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, OUT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] ch_data_in_q, ch_data_in_d;
  logic              noise_off_q, noise_off_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_bad_q, m_bad_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    retry_d      = retry_q;
    wait_d       = wait_q;
    ch_data_in_d = ch_data_in_q;
    noise_off_d  = noise_off_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_bad_d      = m_bad_q;
    err_d        = err_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        // noise_off only tracks its request between transfers
        noise_off_d = cfg_noise_off;
        if (s_valid) begin
          tx_d    = s_data;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        ch_data_in_d = tx_q;
        wait_d       = WW'(CH_LATENCY);
        state_d      = WAIT;
      end
      WAIT: begin
        wait_d = wait_q - WW'(1);
        if (wait_q == WW'(1)) state_d = CHECK;
      end
      CHECK: begin
        if (!ch_error) begin
          m_data_d  = ch_data_out;
          m_bad_d   = 1'b0;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            // retries exhausted: pass the corrupted word on, flagged
            m_data_d  = ch_data_out;
            m_bad_d   = 1'b1;
            m_valid_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            state_d   = OUT;
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      retry_q      <= '0;
      wait_q       <= '0;
      ch_data_in_q <= '0;
      noise_off_q  <= 1'b1;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_bad_q      <= 1'b0;
      err_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      retry_q      <= retry_d;
      wait_q       <= wait_d;
      ch_data_in_q <= ch_data_in_d;
      noise_off_q  <= noise_off_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_bad_q      <= m_bad_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  assign s_ready    = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ch_data_in = ch_data_in_q;
  assign noise_off  = noise_off_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_bad      = m_bad_q;
  assign err_count  = err_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_channel_arq_controller.sv
// Bench for channel_arq_controller: delay-line channel model, table vectors, randomized transfers.
// Edge numbering: the accepting edge is edge 1.
module tb_channel_arq_controller;
  localparam int DW = 24;
  localparam int L  = 2;
  localparam int MR = 3;
  localparam int CW = 16;
  localparam logic [DW-1:0] MASK = 24'hFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] s_data, ch_data_in, ch_data_out, m_data;
  logic          s_valid, s_ready, ch_error, noise_off, cfg_noise_off;
  logic          m_valid, m_ready, m_bad, busy;
  logic [CW-1:0] err_count, drop_count;

  channel_arq_controller #(.DATA_W(DW), .CH_LATENCY(L), .MAX_RETRIES(MR), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ch_data_in(ch_data_in), .ch_data_out(ch_data_out), .ch_error(ch_error),
    .noise_off(noise_off), .cfg_noise_off(cfg_noise_off), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_bad(m_bad), .err_count(err_count), .drop_count(drop_count), .busy(busy));

  // Channel: L-cycle delay line; an errored cycle also inverts the data word.
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= ch_data_in;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign ch_data_out = pipe[L-1] ^ (ch_error ? MASK : '0);

  // Second instance: no retries, 2-bit counters, channel always in error, loopback data.
  logic [DW-1:0] s_data1, ch_data_in1, m_data1;
  logic          s_valid1, s_ready1, noise_off1, m_valid1, m_bad1, busy1;
  logic          ch_error1 = 1'b1;
  logic          m_ready1  = 1'b1;
  logic          cfg1      = 1'b0;
  logic [1:0]    err_count1, drop_count1;

  channel_arq_controller #(.DATA_W(DW), .CH_LATENCY(L), .MAX_RETRIES(0), .CNT_W(2)) u_dut0 (
    .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .ch_data_in(ch_data_in1), .ch_data_out(ch_data_in1), .ch_error(ch_error1),
    .noise_off(noise_off1), .cfg_noise_off(cfg1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_bad(m_bad1), .err_count(err_count1), .drop_count(drop_count1), .busy(busy1));

  int checks = 0;
  int errors = 0;
  int m_err  = 0;
  int m_drop = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            nerr;
    int            hold;
    int            exp_edge;
    logic          exp_bad;
    logic [DW-1:0] exp_data;
    int            exp_err;
    int            exp_drop;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic vec_t model(input logic [DW-1:0] d, input int nerr, input int hold);
    vec_t v;
    int   attempts;
    attempts   = imin(nerr, MR) + 1;
    v.d        = d;
    v.nerr     = nerr;
    v.hold     = hold;
    v.exp_edge = 1 + (L + 2) * attempts;
    v.exp_bad  = (nerr > MR);
    v.exp_data = v.exp_bad ? (d ^ MASK) : d;
    v.exp_err  = imin(m_err + imin(nerr, MR + 1), (1 << CW) - 1);
    v.exp_drop = imin(m_drop + (v.exp_bad ? 1 : 0), (1 << CW) - 1);
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int   rise;
    bit   stable, nz_ok;
    logic nz_exp;
    nz_exp = cfg_noise_off;
    @(negedge clk);
    chk({tag, "_s_ready_idle"}, s_ready, 1);
    s_data  = v.d;
    s_valid = 1'b1;
    rise    = 0;
    nz_ok   = 1'b1;
    for (int e = 1; e <= 150 && rise == 0; e++) begin
      // errors only matter on CHECK edges; elsewhere drive noise on ch_error and m_ready
      if (e > 1 && (e - 1) % (L + 2) == 0) ch_error = (((e - 1) / (L + 2)) - 1) < v.nerr;
      else                                 ch_error = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (e == 1) s_valid = 1'b0;
      if (noise_off !== nz_exp) nz_ok = 1'b0;
      if (m_valid === 1'b1) rise = e;
    end
    m_ready  = 1'b0;
    ch_error = 1'b0;
    chk({tag, "_rise_edge"}, rise, v.exp_edge);
    chk({tag, "_m_data"}, m_data, v.exp_data);
    chk({tag, "_m_bad"}, m_bad, v.exp_bad);
    chk({tag, "_err_count"}, err_count, v.exp_err);
    chk({tag, "_drop_count"}, drop_count, v.exp_drop);
    chk({tag, "_noise_stable"}, nz_ok, 1);
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      s_valid = 1'b1;
      s_data  = ~v.d;
      @(posedge clk);
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== v.exp_data || m_bad !== v.exp_bad ||
          s_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    if (v.hold > 0) chk({tag, "_hold_stable"}, stable, 1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, "_exit_m_valid"}, m_valid, 0);
    chk({tag, "_exit_s_ready"}, s_ready, 1);
    chk({tag, "_ch_data_in_held"}, ch_data_in, v.d);
    m_err  = v.exp_err;
    m_drop = v.exp_drop;
  endtask

  initial begin
    int   seen;
    bit   nz_ok;
    vec_t v;

    tbl[0] = '{24'h000001, 0,  0,  5, 1'b0, 24'h000001, 0, 0};
    tbl[1] = '{24'h123456, 99, 0, 17, 1'b1, 24'hEDCBA9, 4, 1};
    tbl[2] = '{24'h0F0F0F, 1,  0,  9, 1'b0, 24'h0F0F0F, 5, 1};
    tbl[3] = '{24'hABCDEF, 2,  0, 13, 1'b0, 24'hABCDEF, 2, 0};
    tbl[4] = '{24'hFFFFFF, 0, 10,  5, 1'b0, 24'hFFFFFF, 2, 0};
    tbl[5] = '{24'h000000, 3,  2, 17, 1'b0, 24'h000000, 5, 0};
    tbl[6] = '{24'hA5A5A5, 4,  1, 17, 1'b1, 24'h5A5A5A, 9, 1};

    reset = 1'b0; s_data = '0; s_valid = 1'b0; ch_error = 1'b0; m_ready = 1'b0;
    cfg_noise_off = 1'b0; s_data1 = '0; s_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_bad", m_bad, 0);
    chk("rst_ch_data_in", ch_data_in, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_noise_off", noise_off, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_noise_follows_cfg", noise_off, 0);

    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        // reset while waiting on the channel: sample is discarded, counters cleared
        @(negedge clk);
        s_data = 24'h777777; s_valid = 1'b1; ch_error = 1'b0;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_reset_err_count", err_count, 5);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_bad", m_bad, 0);
        chk("mid_rst_ch_data_in", ch_data_in, 0);
        chk("mid_rst_noise_off", noise_off, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
          @(posedge clk); @(negedge clk);
          if (m_valid !== 1'b0) seen = 1;
        end
        m_ready = 1'b0;
        chk("post_rst_no_delivery", seen, 0);
        m_err = 0; m_drop = 0;
      end
      run_txn(tbl[i], $sformatf("tbl%0d", i));
    end

    // noise_off request changes mid-transfer: applied only once back in IDLE
    cfg_noise_off = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("nz_idle_set", noise_off, 1);
    s_data = 24'h135790; s_valid = 1'b1; ch_error = 1'b0;
    nz_ok = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 1) s_valid = 1'b0;
      if (e == 2) cfg_noise_off = 1'b0;
      if (noise_off !== 1'b1) nz_ok = 1'b0;
    end
    chk("nz_held_in_transfer", nz_ok, 1);
    chk("nz_m_valid", m_valid, 1);
    chk("nz_m_data", m_data, 24'h135790);
    m_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_ready = 1'b0;
    chk("nz_at_idle_entry", noise_off, 1);
    @(posedge clk); @(negedge clk);
    chk("nz_after_idle_edge", noise_off, 0);

    for (int r = 0; r < 20; r++) begin
      v = model(DW'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      run_txn(v, $sformatf("rnd%0d", r));
    end

    // MAX_RETRIES=0 instance: every sample dropped, 2-bit counters saturate at 3
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      s_data1  = DW'(k * 24'h010203);
      s_valid1 = 1'b1;
      seen = 0;
      for (int e = 1; e <= 20 && seen == 0; e++) begin
        @(posedge clk); @(negedge clk);
        if (e == 1) s_valid1 = 1'b0;
        if (m_valid1 === 1'b1) seen = e;
      end
      chk($sformatf("mr0_%0d_rise_edge", k), seen, L + 3);
      chk($sformatf("mr0_%0d_m_bad", k), m_bad1, 1);
      chk($sformatf("mr0_%0d_m_data", k), m_data1, DW'(k * 24'h010203));
      chk($sformatf("mr0_%0d_err_count", k), err_count1, imin(k, 3));
      chk($sformatf("mr0_%0d_drop_count", k), drop_count1, imin(k, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
